// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//
// Chart-playback source for the hit/miss judge. Each chart word read from a
// synchronous ROM carries a duration in beat ticks and a 5-bit note pattern.
// The pattern is shown on notes_to_play for a hit window of
// min(WINDOW_TICKS, dur-1) ticks, then the rest of the entry is silent.
// Because the window is never longer than dur-1 ticks, there is always at
// least one silent tick between entries, so the judge can return to idle.
// A duration of 0 marks the end of the chart. The judge's hit/miss pulses
// are accumulated into saturating hit, miss and streak counters.
//
// Optional feature, selected with the macro CHART_LOOP_EN:
//   When defined, an end marker or the last ROM address restarts the chart
//   from address 0 instead of entering DONE. song_done then pulses for one
//   clock, and the score counters are kept.
//
// Parameters:
//   ADDR_W        chart ROM address width (up to 2^ADDR_W entries)
//   TICK_DIV      clk cycles per beat tick (>= 2)
//   WINDOW_TICKS  maximum number of ticks an entry's notes are shown (>= 1)
//
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   start           level; starts playback from address 0 when idle or done
//   pause           freezes the tick timing while playing
//   stop            synchronous abort to idle; overrides start and pause
//   rom_addr        chart ROM address
//   rom_data        chart word {dur[7:0], notes[4:0]}; valid 1 clk after addr
//   note_hit/miss   pulses from the judge
//   notes_to_play   pattern presented to the judge (0 = no note)
//   playing         high while fetching or playing entries
//   song_done       high once the chart has finished
//   hits, misses    saturating 16-bit counters
//   streak          consecutive hits, saturating at 255
// ---------------------------------------------------------------------------
module note_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int TICK_DIV     = 50000,
  parameter int WINDOW_TICKS = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [12:0]       rom_data,
  input  logic              note_hit,
  input  logic              note_miss,
  output logic [4:0]        notes_to_play,
  output logic              playing,
  output logic              song_done,
  output logic [15:0]       hits,
  output logic [15:0]       misses,
  output logic [7:0]        streak
);

  localparam int                DIV_W     = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]        WIN_CAP   = (WINDOW_TICKS > 255) ? 8'd255 : 8'(WINDOW_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [4:0]        notes_d;
  logic [7:0]        dur_q, dur_d;
  logic [7:0]        win_q, win_d;
  logic [7:0]        tick_q, tick_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       hits_d, misses_d;
  logic [7:0]        streak_d;
  logic              done_d, playing_d;
  logic              end_song;
  logic [7:0]        entry_dur, entry_win, tick_next;

  // Fields of the chart word currently on the ROM bus, and the window the
  // entry would get: min(WINDOW_TICKS, dur-1). Only used in WAIT, where
  // dur is known to be non-zero, so dur-1 cannot underflow there.
  always_comb begin
    entry_dur = rom_data[12:5];
    entry_win = ((entry_dur - 8'd1) < WIN_CAP) ? (entry_dur - 8'd1) : WIN_CAP;
    tick_next = tick_q + 8'd1;
  end

  // Next-state and next-output logic. Scoring runs first so that the
  // start/stop handling below can override it (start clears the score).
  always_comb begin
    state_d   = state;
    addr_d    = rom_addr;
    notes_d   = notes_to_play;
    dur_d     = dur_q;
    win_d     = win_q;
    tick_d    = tick_q;
    div_d     = div_q;
    hits_d    = hits;
    misses_d  = misses;
    streak_d  = streak;
    done_d    = 1'b0;
    playing_d = 1'b0;
    end_song  = 1'b0;

    // A miss always wins over a simultaneous hit and breaks the streak.
    if (state != S_IDLE) begin
      if (note_miss) begin
        if (misses != 16'hFFFF) misses_d = misses + 16'd1;
        streak_d = 8'd0;
      end else if (note_hit) begin
        if (hits != 16'hFFFF) hits_d = hits + 16'd1;
        if (streak != 8'hFF) streak_d = streak + 8'd1;
      end
    end

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      notes_d = 5'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_FETCH;
            addr_d   = '0;
            notes_d  = 5'd0;
            hits_d   = 16'd0;
            misses_d = 16'd0;
            streak_d = 8'd0;
          end
        end
        S_FETCH: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (entry_dur == 8'd0) begin
            end_song = 1'b1;
          end else begin
            dur_d   = entry_dur;
            win_d   = entry_win;
            tick_d  = 8'd0;
            div_d   = '0;
            notes_d = (entry_win != 8'd0) ? rom_data[4:0] : 5'd0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (div_q == DIV_LAST) begin
              div_d  = '0;
              tick_d = tick_next;
              if (tick_next == win_q) notes_d = 5'd0;
              if (tick_next == dur_q) begin
                if (rom_addr == ADDR_LAST) begin
                  end_song = 1'b1;
                end else begin
                  addr_d  = rom_addr + ADDR_W'(1);
                  state_d = S_FETCH;
                end
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (end_song) begin
        notes_d = 5'd0;
`ifdef CHART_LOOP_EN
        state_d = S_FETCH;
        addr_d  = '0;
        done_d  = 1'b1;
`else
        state_d = S_DONE;
`endif
      end
    end

`ifndef CHART_LOOP_EN
    done_d = (state_d == S_DONE);
`endif
    playing_d = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_PLAY);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      rom_addr      <= '0;
      notes_to_play <= 5'd0;
      dur_q         <= 8'd0;
      win_q         <= 8'd0;
      tick_q        <= 8'd0;
      div_q         <= '0;
      hits          <= 16'd0;
      misses        <= 16'd0;
      streak        <= 8'd0;
      song_done     <= 1'b0;
      playing       <= 1'b0;
    end else begin
      state         <= state_d;
      rom_addr      <= addr_d;
      notes_to_play <= notes_d;
      dur_q         <= dur_d;
      win_q         <= win_d;
      tick_q        <= tick_d;
      div_q         <= div_d;
      hits          <= hits_d;
      misses        <= misses_d;
      streak        <= streak_d;
      song_done     <= done_d;
      playing       <= playing_d;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
//
// Self-checking bench for note_sequencer. A behavioural model tracks the
// song position as "active PLAY cycles elapsed in the current entry" and
// derives every output from that each cycle. Directed scenarios add literal
// expectations; a randomized phase follows. Honors CHART_LOOP_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_note_sequencer;

  localparam int ADDR_W       = 3;
  localparam int TICK_DIV     = 4;
  localparam int WINDOW_TICKS = 2;
  localparam int LAST_ADDR    = (1 << ADDR_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_WAIT  = 2;
  localparam int M_PLAY  = 3;
  localparam int M_DONE  = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start, pause, stop, note_hit, note_miss;
  logic [ADDR_W-1:0] rom_addr;
  logic [12:0]       rom_data;
  logic [4:0]        notes_to_play;
  logic              playing, song_done;
  logic [15:0]       hits, misses;
  logic [7:0]        streak;

  logic [12:0] chart [0:LAST_ADDR];

  int checks = 0;
  int errors = 0;

  // model state
  int m_mode, m_addr, m_pat, m_dur, m_elapsed;
  int m_hits, m_misses, m_streak;
  logic m_loop_pulse;

  note_sequencer #(
    .ADDR_W(ADDR_W),
    .TICK_DIV(TICK_DIV),
    .WINDOW_TICKS(WINDOW_TICKS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .pause(pause),
    .stop(stop),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .note_hit(note_hit),
    .note_miss(note_miss),
    .notes_to_play(notes_to_play),
    .playing(playing),
    .song_done(song_done),
    .hits(hits),
    .misses(misses),
    .streak(streak)
  );

  always #5 clk = ~clk;

  // synchronous chart ROM
  always @(posedge clk) rom_data <= chart[rom_addr];

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_addr = 0; m_pat = 0; m_dur = 0; m_elapsed = 0;
    m_hits = 0; m_misses = 0; m_streak = 0; m_loop_pulse = 1'b0;
  endtask

  function automatic int exp_notes();
    int win;
    if (m_mode != M_PLAY) return 0;
    win = (m_dur - 1 < WINDOW_TICKS) ? m_dur - 1 : WINDOW_TICKS;
    return (m_elapsed < win * TICK_DIV) ? m_pat : 0;
  endfunction

  function automatic logic exp_done();
`ifdef CHART_LOOP_EN
    return m_loop_pulse;
`else
    return (m_mode == M_DONE);
`endif
  endfunction

  task automatic model_end_song();
`ifdef CHART_LOOP_EN
    m_mode = M_FETCH; m_addr = 0; m_loop_pulse = 1'b1;
`else
    m_mode = M_DONE;
`endif
  endtask

  // Advance the model by one clock with the given inputs.
  task automatic model_step(input logic s, input logic p, input logic st, input logic h, input logic m);
    int d;
    m_loop_pulse = 1'b0;
    if (m_mode != M_IDLE) begin
      if (m) begin
        if (m_misses < 65535) m_misses++;
        m_streak = 0;
      end else if (h) begin
        if (m_hits < 65535) m_hits++;
        if (m_streak < 255) m_streak++;
      end
    end
    if (st) begin
      m_mode = M_IDLE; m_addr = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: if (s) begin
          m_mode = M_FETCH; m_addr = 0; m_hits = 0; m_misses = 0; m_streak = 0;
        end
        M_FETCH: m_mode = M_WAIT;
        M_WAIT: begin
          d = int'(chart[m_addr[ADDR_W-1:0]][12:5]);
          if (d == 0) model_end_song();
          else begin
            m_dur = d; m_pat = int'(chart[m_addr[ADDR_W-1:0]][4:0]);
            m_elapsed = 0; m_mode = M_PLAY;
          end
        end
        M_PLAY: if (!p) begin
          m_elapsed++;
          if (m_elapsed == m_dur * TICK_DIV) begin
            if (m_addr == LAST_ADDR) model_end_song();
            else begin m_addr++; m_mode = M_FETCH; end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic checkOutput();
    check_value("rom_addr", 32'(rom_addr), m_addr);
    check_value("notes_to_play", 32'(notes_to_play), exp_notes());
    check_value("playing", 32'(playing),
                32'((m_mode == M_FETCH) || (m_mode == M_WAIT) || (m_mode == M_PLAY)));
    check_value("song_done", 32'(song_done), 32'(exp_done()));
    check_value("hits", 32'(hits), m_hits);
    check_value("misses", 32'(misses), m_misses);
    check_value("streak", 32'(streak), m_streak);
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic st, input logic h, input logic m);
    start = s; pause = p; stop = st; note_hit = h; note_miss = m;
    model_step(s, p, st, h, m);
  endtask

  // One cycle: compare at the falling edge, then drive the next inputs.
  task automatic run_cycle(input logic s, input logic p, input logic st, input logic h, input logic m);
    @(negedge clk);
    checkOutput();
    applyStimulus(s, p, st, h, m);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_value("async_reset_notes", 32'(notes_to_play), 0);
    check_value("async_reset_hits", 32'(hits), 0);
    check_value("async_reset_playing", 32'(playing), 0);
    model_reset();
    @(negedge clk);
    checkOutput();
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic s, p, st, h, m;
    resetn = 1'b0;
    start = 1'b0; pause = 1'b0; stop = 1'b0; note_hit = 1'b0; note_miss = 1'b0;
    for (int a = 0; a <= LAST_ADDR; a++) chart[a] = 13'd0;
    model_reset();

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_value("reset_rom_addr", 32'(rom_addr), 0);
    check_value("reset_notes", 32'(notes_to_play), 0);
    check_value("reset_playing", 32'(playing), 0);
    check_value("reset_song_done", 32'(song_done), 0);
    check_value("reset_hits", 32'(hits), 0);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_idle(3);

    // basic entry {dur=4, notes=00101} then end marker
    $display("[TB] basic entry and end marker");
    chart[0] = {8'd4, 5'b00101};
    chart[1] = 13'd0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 24; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 2)  check_value("lat_before", 32'(notes_to_play), 0);
      if (i == 3)  check_value("lat_first", 32'(notes_to_play), 32'h05);
      if (i == 10) check_value("win_last", 32'(notes_to_play), 32'h05);
      if (i == 11) check_value("win_end", 32'(notes_to_play), 0);
      if (i == 18) check_value("rest_last", 32'(notes_to_play), 0);
      if (i == 19) check_value("next_addr", 32'(rom_addr), 1);
`ifdef CHART_LOOP_EN
      if (i == 21) check_value("loop_done_pulse", 32'(song_done), 1);
      if (i == 21) check_value("loop_addr0", 32'(rom_addr), 0);
      if (i == 22) check_value("loop_done_clear", 32'(song_done), 0);
      if (i == 23) check_value("loop_notes_again", 32'(notes_to_play), 32'h05);
`else
      if (i == 21) check_value("song_done", 32'(song_done), 1);
      if (i == 21) check_value("done_not_playing", 32'(playing), 0);
`endif
    end
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // short entries: dur=2 (one tick of notes) and dur=1 (pure rest)
    $display("[TB] short entries");
    chart[0] = {8'd2, 5'b10000};
    chart[1] = {8'd1, 5'b01000};
    chart[2] = 13'd0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 6)  check_value("dur2_shown", 32'(notes_to_play), 32'h10);
      if (i == 7)  check_value("dur2_gap", 32'(notes_to_play), 0);
      if (i == 14) check_value("dur1_rest", 32'(notes_to_play), 0);
      if (i == 14) check_value("dur1_playing", 32'(playing), 1);
    end
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // pause for 10 clocks mid-window delays the window end by 10 clocks
    $display("[TB] pause");
    chart[0] = {8'd4, 5'b00011};
    chart[1] = 13'd0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 25; i++) begin
      run_cycle(1'b0, (i >= 4 && i <= 13), 1'b0, 1'b0, 1'b0);
      if (i == 12) check_value("pause_held", 32'(notes_to_play), 32'h03);
      if (i == 20) check_value("pause_win_last", 32'(notes_to_play), 32'h03);
      if (i == 21) check_value("pause_win_end", 32'(notes_to_play), 0);
    end
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // scoring, stop-with-start, restart clears counters
    $display("[TB] scoring and stop");
    chart[0] = {8'd20, 5'b00001};
    chart[1] = 13'd0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_idle(4);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_value("three_hits", 32'(hits), 3);
    check_value("streak3", 32'(streak), 3);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("miss_hits", 32'(hits), 3);
    check_value("miss_streak", 32'(streak), 0);
    check_value("miss_count", 32'(misses), 1);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("both_misses", 32'(misses), 2);
    check_value("both_hits", 32'(hits), 3);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("stop_playing", 32'(playing), 0);
    check_value("stop_addr", 32'(rom_addr), 0);
    check_value("stop_hits_kept", 32'(hits), 4);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("restart_hits", 32'(hits), 0);
    check_value("restart_misses", 32'(misses), 0);

    // asynchronous reset in the middle of a song
    $display("[TB] mid-song reset");
    run_idle(2);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("pre_reset_hits", 32'(hits), 2);
    mid_reset();
    run_idle(2);

    // streak saturates at 255
    $display("[TB] streak saturation");
    chart[0] = {8'd255, 5'b00100};
    chart[1] = 13'd0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_idle(3);
    for (int i = 0; i < 260; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("streak_sat", 32'(streak), 255);
    check_value("hits_260", 32'(hits), 260);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // full ROM with no end marker: the last address ends the song
    $display("[TB] last address");
    for (int a = 0; a <= LAST_ADDR; a++) chart[a] = {8'd1, 5'(a + 1)};
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_idle(60);
`ifndef CHART_LOOP_EN
    check_value("last_addr_done", 32'(song_done), 1);
    check_value("last_addr_hold", 32'(rom_addr), LAST_ADDR);
`endif
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // randomized playback against the model
    $display("[TB] random phase");
    for (int round = 0; round < 3; round++) begin
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int a = 0; a <= LAST_ADDR; a++)
        chart[a] = {8'($urandom_range(0, 5)), 5'($urandom_range(0, 31))};
      for (int c = 0; c < 1200; c++) begin
        s  = ($urandom_range(0, 39) == 0);
        st = ($urandom_range(0, 96) == 0);
        p  = ($urandom_range(0, 5) == 0);
        h  = !s && !st && ($urandom_range(0, 4) == 0);
        m  = !s && !st && ($urandom_range(0, 10) == 0);
        run_cycle(s, p, st, h, m);
      end
    end
    run_idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
